// File: rtl/switch_pkg.sv
// Shared defaults, config address map and dispatch FSM states for the switch core.
// Latency: n/a (constants and types only).
// Backpressure: n/a.
package switch_pkg;

  localparam int DEF_NUM_PORTS  = 4;
  localparam int DEF_DATA_W     = 8;
  localparam int DEF_FIFO_DEPTH = 4;

  localparam logic [7:0] ADDR_MATCH_BASE = 8'h00;
  localparam logic [7:0] ADDR_MASK       = 8'h10;
  localparam logic [7:0] ADDR_DROP_CNT   = 8'h20;

  typedef enum logic {
    ST_IDLE     = 1'b0,
    ST_DISPATCH = 1'b1
  } sw_state_t;

  // Config address of the match register for output port idx.
  function automatic logic [7:0] match_addr(input int idx);
    return ADDR_MATCH_BASE + 8'(idx);
  endfunction

endpackage

// File: rtl/switch_port_fifo.sv
// Per-port first-word-fall-through FIFO holding switched words.
// Latency: a pushed word is visible at head_dat/not_empty right after the push edge.
// Backpressure: full is raised from the pre-edge count; pushes while full are ignored.
module switch_port_fifo #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push,
  input  logic [DATA_W-1:0] push_dat,
  input  logic              pop,
  output logic [DATA_W-1:0] head_dat,
  output logic              not_empty,
  output logic              full
);

  localparam int AW = $clog2(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic [AW:0]       count;
  logic              do_push;
  logic              do_pop;

  assign not_empty = (count != '0);
  assign full      = (count == (AW+1)'(DEPTH));
  assign do_push   = push && !full;
  assign do_pop    = pop && not_empty;
  assign head_dat  = mem[rd_ptr];

  // Storage write; contents need no reset because count gates visibility.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= push_dat;
    end
  end

  // Pointers wrap naturally since DEPTH is a power of two; count tracks occupancy.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/switch_core_param.sv
// Single-input multicast switch: match-table routing of whole words into per-port FIFOs; optional drop counter under SWITCH_DROP_CNT_EN.
// Latency: accept edge k, word at port_out/port_ready after edge k+1; one word per two cycles peak.
// Backpressure: read_out low outside IDLE; a held word waits until every matched FIFO has room (atomic multicast).
module switch_core_param
  import switch_pkg::*;
#(
  parameter int NUM_PORTS  = DEF_NUM_PORTS,
  parameter int DATA_W     = DEF_DATA_W,
  parameter int FIFO_DEPTH = DEF_FIFO_DEPTH
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              sw_enable_in,
  input  logic [DATA_W-1:0]                 data_in,
  output logic                              read_out,
  output logic [NUM_PORTS-1:0][DATA_W-1:0]  port_out,
  output logic [NUM_PORTS-1:0]              port_ready,
  input  logic [NUM_PORTS-1:0]              port_read,
  input  logic                              mem_sel_en,
  input  logic                              mem_wr_rd_s,
  input  logic [7:0]                        mem_addr,
  input  logic [DATA_W-1:0]                 mem_wr_data,
  output logic [DATA_W-1:0]                 mem_rd_data,
  output logic                              mem_ack
);

  // Config state
  logic [DATA_W-1:0] match_q [NUM_PORTS];
  logic [DATA_W-1:0] mask_q;
  logic [DATA_W-1:0] rd_mux;
  logic              cfg_wr;
  logic              cfg_rd;

  // Dispatch state
  sw_state_t              state_q;
  sw_state_t              state_d;
  logic                   accept;
  logic [NUM_PORTS-1:0]   match_vec;
  logic [NUM_PORTS-1:0]   hold_vec;
  logic [DATA_W-1:0]      hold_dat;
  logic [NUM_PORTS-1:0]   push_vec;
  logic                   room_ok;

  // FIFO side
  logic [NUM_PORTS-1:0]              fifo_ne;
  logic [NUM_PORTS-1:0]              fifo_full;
  logic [NUM_PORTS-1:0][DATA_W-1:0]  fifo_head;

`ifdef SWITCH_DROP_CNT_EN
  logic              drop_evt;
  logic [DATA_W-1:0] drop_cnt_q;
`endif

  assign cfg_wr = mem_sel_en && mem_wr_rd_s;
  assign cfg_rd = mem_sel_en && !mem_wr_rd_s;

  // Config register writes; unmapped addresses fall through untouched.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_PORTS; i++) match_q[i] <= '0;
      mask_q <= '0;
    end else if (cfg_wr) begin
      for (int i = 0; i < NUM_PORTS; i++) begin
        if (mem_addr == match_addr(i)) match_q[i] <= mem_wr_data;
      end
      if (mem_addr == ADDR_MASK) mask_q <= mem_wr_data;
    end
  end

  // Read-data mux; anything unmapped reads as zero.
  always_comb begin
    rd_mux = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (mem_addr == match_addr(i)) rd_mux = match_q[i];
    end
    if (mem_addr == ADDR_MASK) rd_mux = mask_q;
`ifdef SWITCH_DROP_CNT_EN
    if (mem_addr == ADDR_DROP_CNT) rd_mux = drop_cnt_q;
`endif
  end

  // One-cycle ack per strobed access; read data is held until the next read.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mem_ack     <= 1'b0;
      mem_rd_data <= '0;
    end else begin
      mem_ack <= mem_sel_en;
      if (cfg_rd) mem_rd_data <= rd_mux;
    end
  end

`ifdef SWITCH_DROP_CNT_EN
  // Saturating count of words dropped for lack of any matching port; any write clears it.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      drop_cnt_q <= '0;
    end else if (cfg_wr && (mem_addr == ADDR_DROP_CNT)) begin
      drop_cnt_q <= '0;
    end else if (drop_evt && (drop_cnt_q != '1)) begin
      drop_cnt_q <= drop_cnt_q + 1'b1;
    end
  end
`endif

  // Match vector from the live config; ports beyond the mask width are never enabled.
  for (genvar g = 0; g < NUM_PORTS; g++) begin : g_match
    if (g < DATA_W) begin : g_en
      assign match_vec[g] = mask_q[g] && (match_q[g] == data_in);
    end else begin : g_off
      assign match_vec[g] = 1'b0;
    end
  end

  assign accept  = sw_enable_in && read_out;
  assign room_ok = ((hold_vec & fifo_full) == '0);

  // FSM state register.
  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // FSM next state: leave DISPATCH on drop or on a complete multicast push.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:     if (accept) state_d = ST_DISPATCH;
      ST_DISPATCH: if (room_ok) state_d = ST_IDLE;
      default:     state_d = ST_IDLE;
    endcase
  end

  // FSM outputs: accept only in IDLE, push all matched ports together or none.
  always_comb begin
    read_out = rst_n && (state_q == ST_IDLE);
    push_vec = '0;
    if (rst_n && (state_q == ST_DISPATCH) && room_ok) push_vec = hold_vec;
`ifdef SWITCH_DROP_CNT_EN
    drop_evt = rst_n && (state_q == ST_DISPATCH) && (hold_vec == '0);
`endif
  end

  // Held word and its routing, frozen at acceptance so later config writes cannot retarget it.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hold_dat <= '0;
      hold_vec <= '0;
    end else if (accept) begin
      hold_dat <= data_in;
      hold_vec <= match_vec;
    end
  end

  for (genvar g = 0; g < NUM_PORTS; g++) begin : g_port
    switch_port_fifo #(
      .DATA_W (DATA_W),
      .DEPTH  (FIFO_DEPTH)
    ) u_fifo (
      .clk       (clk),
      .rst_n     (rst_n),
      .push      (push_vec[g]),
      .push_dat  (hold_dat),
      .pop       (port_read[g]),
      .head_dat  (fifo_head[g]),
      .not_empty (fifo_ne[g]),
      .full      (fifo_full[g])
    );

    assign port_ready[g] = fifo_ne[g] && rst_n;
    assign port_out[g]   = port_ready[g] ? fifo_head[g] : '0;
  end

endmodule

// File: tb/tb_switch_core_param.sv
// Directed self-checking bench for switch_core_param with default parameters.
// Latency: inputs driven 1 time unit after a rising edge, outputs sampled at the same point.
// Backpressure: exercised by filling port 0 and holding a word in DISPATCH.
module tb_switch_core_param;

  localparam int NP = 4;
  localparam int DW = 8;

  logic               clk;
  logic               rst_n;
  logic               sw_enable_in;
  logic [DW-1:0]      data_in;
  logic               read_out;
  logic [NP-1:0][DW-1:0] port_out;
  logic [NP-1:0]      port_ready;
  logic [NP-1:0]      port_read;
  logic               mem_sel_en;
  logic               mem_wr_rd_s;
  logic [7:0]         mem_addr;
  logic [DW-1:0]      mem_wr_data;
  logic [DW-1:0]      mem_rd_data;
  logic               mem_ack;

  int n_chk  = 0;
  int n_pass = 0;

  switch_core_param #(
    .NUM_PORTS  (NP),
    .DATA_W     (DW),
    .FIFO_DEPTH (4)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .sw_enable_in (sw_enable_in),
    .data_in      (data_in),
    .read_out     (read_out),
    .port_out     (port_out),
    .port_ready   (port_ready),
    .port_read    (port_read),
    .mem_sel_en   (mem_sel_en),
    .mem_wr_rd_s  (mem_wr_rd_s),
    .mem_addr     (mem_addr),
    .mem_wr_data  (mem_wr_data),
    .mem_rd_data  (mem_rd_data),
    .mem_ack      (mem_ack)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic cfg_wr(input logic [7:0] a, input logic [DW-1:0] d);
    mem_sel_en  = 1'b1;
    mem_wr_rd_s = 1'b1;
    mem_addr    = a;
    mem_wr_data = d;
    step();
    mem_sel_en  = 1'b0;
    chk("wr_ack", 32'(mem_ack), 32'd1);
    step();
    chk("wr_ack_clr", 32'(mem_ack), 32'd0);
  endtask

  task automatic cfg_rd(input string tag, input logic [7:0] a, input logic [DW-1:0] exp);
    mem_sel_en  = 1'b1;
    mem_wr_rd_s = 1'b0;
    mem_addr    = a;
    step();
    mem_sel_en  = 1'b0;
    chk({tag, "_ack"}, 32'(mem_ack), 32'd1);
    chk(tag, 32'(mem_rd_data), 32'(exp));
    step();
    chk({tag, "_ack_clr"}, 32'(mem_ack), 32'd0);
    chk({tag, "_hold"}, 32'(mem_rd_data), 32'(exp));
  endtask

  // Accept edge then dispatch edge.
  task automatic send_word(input logic [DW-1:0] d);
    sw_enable_in = 1'b1;
    data_in      = d;
    step();
    sw_enable_in = 1'b0;
    step();
  endtask

  task automatic pop(input logic [NP-1:0] which);
    port_read = which;
    step();
    port_read = '0;
  endtask

  initial begin
    logic [DW-1:0] exp_q [4];
    logic [DW-1:0] drop_exp;

    rst_n        = 1'b0;
    sw_enable_in = 1'b0;
    data_in      = '0;
    port_read    = '0;
    mem_sel_en   = 1'b0;
    mem_wr_rd_s  = 1'b0;
    mem_addr     = '0;
    mem_wr_data  = '0;

    // Reset state
    step();
    step();
    chk("rst_read_out", 32'(read_out), 32'd0);
    chk("rst_port_ready", 32'(port_ready), 32'd0);
    chk("rst_ack", 32'(mem_ack), 32'd0);
    chk("rst_rd_data", 32'(mem_rd_data), 32'd0);
    rst_n = 1'b1;
    step();
    chk("post_rst_read_out", 32'(read_out), 32'd1);

    // Config access: match[0], mask, unmapped
    cfg_wr(8'h00, 8'h44);
    cfg_wr(8'h10, 8'h01);
    cfg_rd("rd_match0", 8'h00, 8'h44);
    cfg_wr(8'h7F, 8'hAA);
    cfg_rd("rd_unmapped", 8'h7F, 8'h00);
    cfg_rd("rd_mask", 8'h10, 8'h01);

    // Unicast to port 0
    sw_enable_in = 1'b1;
    data_in      = 8'h44;
    step();
    sw_enable_in = 1'b0;
    chk("uni_dispatch_busy", 32'(read_out), 32'd0);
    chk("uni_not_yet", 32'(port_ready), 32'd0);
    step();
    chk("uni_ready", 32'(port_ready), 32'b0001);
    chk("uni_data", 32'(port_out[0]), 32'h44);
    chk("uni_idle", 32'(read_out), 32'd1);
    pop(4'b0001);
    chk("uni_popped", 32'(port_ready), 32'd0);
    chk("uni_out_zero", 32'(port_out[0]), 32'd0);

    // Multicast to ports 1 and 2
    cfg_wr(8'h01, 8'h55);
    cfg_wr(8'h02, 8'h55);
    cfg_wr(8'h10, 8'h06);
    send_word(8'h55);
    chk("mc_ready", 32'(port_ready), 32'b0110);
    chk("mc_p1", 32'(port_out[1]), 32'h55);
    chk("mc_p2", 32'(port_out[2]), 32'h55);
    chk("mc_p0_zero", 32'(port_out[0]), 32'd0);
    chk("mc_p3_zero", 32'(port_out[3]), 32'd0);
    pop(4'b0110);
    chk("mc_drained", 32'(port_ready), 32'd0);

    // No match: drop
    sw_enable_in = 1'b1;
    data_in      = 8'h99;
    step();
    sw_enable_in = 1'b0;
    chk("drop_busy", 32'(read_out), 32'd0);
    step();
    chk("drop_idle", 32'(read_out), 32'd1);
    chk("drop_no_push", 32'(port_ready), 32'd0);
`ifdef SWITCH_DROP_CNT_EN
    drop_exp = 8'd1;
`else
    drop_exp = 8'd0;
`endif
    cfg_rd("drop_cnt", 8'h20, drop_exp);
    cfg_wr(8'h20, 8'h00);
    cfg_rd("drop_cnt_clr", 8'h20, 8'h00);

    // Fill port 0, distinct keys so order is visible
    cfg_wr(8'h10, 8'h01);
    for (int i = 0; i < 4; i++) begin
      cfg_wr(8'h00, 8'(8'h40 + i));
      send_word(8'(8'h40 + i));
    end
    chk("fill_ready", 32'(port_ready), 32'b0001);
    chk("fill_head", 32'(port_out[0]), 32'h40);

    // Blocked word; a later match change must not retarget it
    cfg_wr(8'h00, 8'h44);
    sw_enable_in = 1'b1;
    data_in      = 8'h44;
    step();
    sw_enable_in = 1'b0;
    cfg_wr(8'h00, 8'h77);
    step();
    chk("full_held", 32'(read_out), 32'd0);
    chk("full_head", 32'(port_out[0]), 32'h40);
    pop(4'b0001);
    chk("pop_edge_no_push", 32'(read_out), 32'd0);
    chk("pop_head", 32'(port_out[0]), 32'h41);
    step();
    chk("push_after_pop", 32'(read_out), 32'd1);
    exp_q[0] = 8'h41;
    exp_q[1] = 8'h42;
    exp_q[2] = 8'h43;
    exp_q[3] = 8'h44;
    for (int i = 0; i < 4; i++) begin
      chk("drain_order", 32'(port_out[0]), 32'(exp_q[i]));
      pop(4'b0001);
    end
    chk("drain_empty", 32'(port_ready), 32'd0);

    // Reset during DISPATCH
    sw_enable_in = 1'b1;
    data_in      = 8'h77;
    step();
    sw_enable_in = 1'b0;
    chk("rst_disp_busy", 32'(read_out), 32'd0);
    rst_n = 1'b0;
    chk("rst_comb_read_out", 32'(read_out), 32'd0);
    step();
    chk("rst_disp_ready", 32'(port_ready), 32'd0);
    chk("rst_disp_ack", 32'(mem_ack), 32'd0);
    rst_n = 1'b1;
    step();
    step();
    chk("rst_disp_never_out", 32'(port_ready), 32'd0);
    chk("rst_disp_idle", 32'(read_out), 32'd1);
    cfg_rd("rst_mask", 8'h10, 8'h00);
    cfg_rd("rst_match0", 8'h00, 8'h00);
    chk("rst_disp_still_empty", 32'(port_ready), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
